// File: rtl/rng_sched.sv
// Round-robin scheduler that shares one external LFSR between NREQ requesters.
// Optional grant counter output is enabled by defining RNG_SCHED_STATS_EN.
module rng_sched #(
  parameter int          NREQ   = 4,
  parameter int          N      = 32,
  parameter logic [N-1:0] SEED  = {{(N-1){1'b0}}, 1'b1},
  parameter int          WARMUP = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [N-1:0]    rnd_data,
  output logic            rnd_valid,
  input  logic [N-1:0]    seed_in,
  input  logic            seed_load,
  output logic            lfsr_load,
  output logic [N-1:0]    lfsr_seed,
  output logic            lfsr_en,
  input  logic [N-1:0]    lfsr_q,
`ifdef RNG_SCHED_STATS_EN
  output logic            busy,
  output logic [15:0]     grant_cnt
`else
  output logic            busy
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {LOAD, WARM, IDLE, STEP, DELIVER} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic [PW-1:0]   pick;
  logic [N-1:0]    pend;
  logic [N-1:0]    data_hold;
  logic [7:0]      wcnt;
  logic            take_req;

  // Rotate the request vector so the search always begins at ptr.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [PW-1:0]   p);
    logic [2*NREQ-1:0] rot;
    logic [PW-1:0]     w;
    logic              found;
    rot   = {r, r} >> p;
    w     = p;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        w     = PW'((int'(p) + k) % NREQ);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] w);
    return PW'((int'(w) + 1) % NREQ);
  endfunction

  assign pick     = rr_pick(req, ptr);
  assign take_req = (state == IDLE) && !seed_load && (|req);

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    state_nx = WARM;
      WARM:    if (wcnt == 8'd1) state_nx = IDLE;
      IDLE: begin
        if (seed_load)  state_nx = LOAD;
        else if (|req)  state_nx = STEP;
      end
      STEP:    state_nx = DELIVER;
      DELIVER: state_nx = IDLE;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LOAD;
      ptr       <= '0;
      win       <= '0;
      pend      <= SEED;
      wcnt      <= 8'(WARMUP);
      data_hold <= '0;
    end else begin
      state <= state_nx;
      if (state == LOAD)
        wcnt <= 8'(WARMUP);
      else if (state == WARM)
        wcnt <= wcnt - 8'd1;
      if (state == IDLE && seed_load)
        pend <= (seed_in == '0) ? SEED : seed_in;
      // Winner is frozen here so a request dropped during STEP is still served.
      if (take_req) begin
        win <= pick;
        ptr <= rr_next(pick);
      end
      if (state == DELIVER)
        data_hold <= lfsr_q;
    end
  end

  // The load strobe is masked while reset is held so it only fires on release.
  assign lfsr_load = (state == LOAD) && !reset;
  assign lfsr_seed = pend;
  assign lfsr_en   = (state == WARM) || (state == STEP);
  assign busy      = (state != IDLE);
  assign rnd_valid = (state == DELIVER);
  assign gnt       = (state == DELIVER) ? (NREQ'(1) << win) : '0;
  assign rnd_data  = (state == DELIVER) ? lfsr_q : data_hold;

`ifdef RNG_SCHED_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      grant_cnt <= '0;
    else if (state == LOAD)
      grant_cnt <= '0;
    else if (state == DELIVER && grant_cnt != 16'hFFFF)
      grant_cnt <= grant_cnt + 16'd1;
  end
`endif

endmodule
